keypad_decoder: RTL and testbench

Downstream companion of the keypad/display scan FSM: consumes the column select `SEL` it produces together with the keypad row lines, and turns the raw row/column matrix into a debounced hex key code with a one-cycle `KEY_VALID` strobe. It runs on the same `mux_rate` clock, so one sample is taken per column slot. It feeds key events to the entry/display logic.

---
 rtl/keypad_decoder_if.sv | 12 +
 rtl/keypad_decoder.sv | 227 ++++++++++++++++++++++
 tb/tb_keypad_decoder.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_decoder_if.sv
// Scan-side bundle between the keypad/display scan FSM and keypad_decoder.
// master = scan/consumer side, slave = decoder.
interface keypad_decoder_if;
  logic [1:0] SEL;
  logic [3:0] ROW;
  logic [3:0] KEY;
  logic       KEY_VALID;
  logic       KEY_DOWN;

  modport master (output SEL, ROW, input KEY, KEY_VALID, KEY_DOWN);
  modport slave  (input SEL, ROW, output KEY, KEY_VALID, KEY_DOWN);
endinterface

// File: rtl/keypad_decoder.sv
// Debounced 4x4 keypad decoder: accumulates one column per mux_rate edge into full scans.
// Optional feature: define KEYPAD_AUTOREPEAT_EN for periodic KEY_VALID re-pulses while held.
//
// state      | meaning
// S_IDLE     | no key accepted, waiting for a clean single-key scan
// S_DEBOUNCE | same single key seen cnt consecutive scans
// S_PRESSED  | key accepted, KEY_DOWN high
// S_RELEASE  | accepted key absent cnt consecutive scans, KEY_DOWN still high
module keypad_decoder #(
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 32
) (
  input logic             mux_rate,
  input logic             reset,
  keypad_decoder_if.slave kp
);

  if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 ||
      REPEAT_SCANS < 2 || REPEAT_SCANS > 255) begin : g_param_check
    $error("keypad_decoder: DEBOUNCE_SCANS or REPEAT_SCANS out of range");
  end

  localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [7:0] RPT = 8'(REPEAT_SCANS);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_PRESSED,
    S_RELEASE
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] cand;
  logic [3:0] key_q;
  logic       valid_q;
  logic       down_q;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [7:0] rpt_cnt;
`endif

  logic       acc_armed;
  logic [1:0] acc_sel;
  logic       acc_hit;
  logic       acc_multi;
  logic       acc_cand;
  logic [3:0] acc_code;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  logic [2:0] n_low;
  logic [3:0] smp_code;
  logic       smp_cand;

  always_comb begin
    n_low    = '0;
    smp_code = '0;
    smp_cand = 1'b0;
    for (int r = 0; r < 4; r++) begin
      if (!kp.ROW[r]) begin
        n_low    = n_low + 3'd1;
        smp_code = key_code(2'(r), kp.SEL);
        if (key_code(2'(r), kp.SEL) == cand) smp_cand = 1'b1;
      end
    end
  end

  // Scan state including the current sample; a SEL=0 sample always starts afresh.
  logic       start_scan;
  logic       cont_scan;
  logic       scan_close;
  logic       scan_hit;
  logic       scan_multi;
  logic       scan_cand;
  logic [3:0] scan_code;
  logic       res_single;

  always_comb begin
    start_scan = (kp.SEL == 2'd0);
    cont_scan  = !start_scan && acc_armed && (kp.SEL == acc_sel + 2'd1);
    scan_close = cont_scan && (kp.SEL == 2'd3);
    scan_hit   = (cont_scan && acc_hit) || (n_low != 3'd0);
    scan_multi = (cont_scan && acc_multi) || (n_low >= 3'd2) ||
                 (cont_scan && acc_hit && (n_low != 3'd0));
    scan_cand  = (cont_scan && acc_cand) || smp_cand;
    scan_code  = (cont_scan && acc_hit) ? acc_code : smp_code;
    res_single = scan_hit && !scan_multi;
  end

  logic [3:0] cnt_next;
  logic       cnt_reach;

  always_comb begin
    cnt_next  = (cnt >= DEB) ? DEB : cnt + 4'd1;
    cnt_reach = (cnt_next == DEB);
  end

  always_ff @(posedge mux_rate) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cand      <= '0;
      key_q     <= '0;
      valid_q   <= 1'b0;
      down_q    <= 1'b0;
      acc_armed <= 1'b0;
      acc_sel   <= '0;
      acc_hit   <= 1'b0;
      acc_multi <= 1'b0;
      acc_cand  <= 1'b0;
      acc_code  <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_cnt   <= '0;
`endif
    end else begin
      valid_q <= 1'b0;

      if (start_scan || cont_scan) begin
        acc_armed <= !scan_close;
        acc_sel   <= kp.SEL;
        acc_hit   <= scan_hit;
        acc_multi <= scan_multi;
        acc_cand  <= scan_cand;
        acc_code  <= scan_code;
      end else begin
        acc_armed <= 1'b0;
      end

      if (scan_close) begin
        case (state)
          S_IDLE: begin
            if (res_single) begin
              cand <= scan_code;
              if (DEB == 4'd1) begin
                state   <= S_PRESSED;
                cnt     <= DEB;
                key_q   <= scan_code;
                valid_q <= 1'b1;
                down_q  <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                rpt_cnt <= '0;
`endif
              end else begin
                state <= S_DEBOUNCE;
                cnt   <= 4'd1;
              end
            end
          end

          S_DEBOUNCE: begin
            if (res_single && scan_code == cand) begin
              cnt <= cnt_next;
              if (cnt_reach) begin
                state   <= S_PRESSED;
                key_q   <= cand;
                valid_q <= 1'b1;
                down_q  <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                rpt_cnt <= '0;
`endif
              end
            end else if (res_single) begin
              cand <= scan_code;
              cnt  <= 4'd1;
            end else begin
              state <= S_IDLE;
            end
          end

          S_PRESSED: begin
            if (!scan_cand) begin
              if (DEB == 4'd1) begin
                state  <= S_IDLE;
                down_q <= 1'b0;
              end else begin
                state <= S_RELEASE;
                cnt   <= 4'd1;
              end
`ifdef KEYPAD_AUTOREPEAT_EN
              rpt_cnt <= '0;
            end else if (rpt_cnt == RPT - 8'd1) begin
              valid_q <= 1'b1;
              rpt_cnt <= '0;
            end else begin
              rpt_cnt <= rpt_cnt + 8'd1;
`endif
            end
          end

          S_RELEASE: begin
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_cnt <= '0;
`endif
            if (scan_cand) begin
              state <= S_PRESSED;
            end else begin
              cnt <= cnt_next;
              if (cnt_reach) begin
                state  <= S_IDLE;
                down_q <= 1'b0;
              end
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign kp.KEY       = key_q;
  assign kp.KEY_VALID = valid_q;
  assign kp.KEY_DOWN  = down_q;

endmodule

// File: tb/tb_keypad_decoder.sv
// Randomized + directed bench for keypad_decoder against a scan-level key-event model.
module tb_keypad_decoder;
  localparam int DEB = 4;
  localparam int RPT = 8;

  logic mux_rate = 1'b0;
  logic reset;
  keypad_decoder_if kif();

  keypad_decoder #(.DEBOUNCE_SCANS(DEB), .REPEAT_SCANS(RPT)) dut (
    .mux_rate(mux_rate),
    .reset   (reset),
    .kp      (kif)
  );

  always #5 mux_rate = ~mux_rate;

  int keymap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

  int checks = 0;
  int errors = 0;

  // model state, expressed as scan-level run lengths
  bit m_armed = 0;
  int m_next_sel = 0;
  int scan_keys[$];
  bit held = 0;
  int held_key = 0;
  int streak_key = 0;
  int streak_len = 0;
  int absent_len = 0;
  int repeat_run = 0;
  int e_key = 0;
  int e_valid = 0;
  int e_down = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void close_scan();
    bit has_held = 0;
    foreach (scan_keys[i]) if (scan_keys[i] == held_key) has_held = 1;
    if (!held) begin
      if (scan_keys.size() == 1) begin
        if (streak_len > 0 && scan_keys[0] == streak_key) streak_len++;
        else begin
          streak_key = scan_keys[0];
          streak_len = 1;
        end
        if (streak_len >= DEB) begin
          held = 1; held_key = streak_key; e_key = streak_key;
          e_valid = 1; e_down = 1; absent_len = 0; repeat_run = 0; streak_len = 0;
        end
      end else streak_len = 0;
    end else if (has_held) begin
      if (absent_len > 0) begin
        absent_len = 0;
        repeat_run = 0;
      end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
        repeat_run++;
        if (repeat_run == RPT) begin
          e_valid = 1;
          repeat_run = 0;
        end
`endif
      end
    end else begin
      absent_len++;
      repeat_run = 0;
      if (absent_len >= DEB) begin
        held = 0; e_down = 0; absent_len = 0; streak_len = 0;
      end
    end
  endfunction

  function automatic void model_step(input int sel, input logic [3:0] row, input bit rst_n);
    e_valid = 0;
    if (!rst_n) begin
      m_armed = 0; held = 0; streak_len = 0; absent_len = 0; repeat_run = 0;
      e_key = 0; e_down = 0;
      return;
    end
    if (sel == 0) begin
      m_armed = 1;
      scan_keys.delete();
    end else if (!(m_armed && sel == m_next_sel)) begin
      m_armed = 0;
      return;
    end
    for (int r = 0; r < 4; r++) if (!row[r]) scan_keys.push_back(keymap[r][sel]);
    m_next_sel = sel + 1;
    if (sel == 3) begin
      m_armed = 0;
      close_scan();
    end
  endfunction

  task automatic drive_sample(input int sel, input logic [15:0] mask, input bit rst_n);
    logic [3:0] row;
    @(negedge mux_rate);
    row = 4'hF;
    for (int r = 0; r < 4; r++) if (mask[keymap[r][sel]]) row[r] = 1'b0;
    kif.SEL = 2'(sel);
    kif.ROW = row;
    reset = rst_n;
    @(posedge mux_rate);
    model_step(sel, row, rst_n);
    #1;
    chk("key", int'(kif.KEY), e_key);
    chk("key_valid", int'(kif.KEY_VALID), e_valid);
    chk("key_down", int'(kif.KEY_DOWN), e_down);
  endtask

  task automatic run_scans(input logic [15:0] mask, input int n);
    for (int s = 0; s < n; s++)
      for (int c = 0; c < 4; c++) drive_sample(c, mask, 1'b1);
  endtask

  task automatic do_reset();
    drive_sample(0, 16'h0, 1'b0);
    drive_sample(1, 16'h0, 1'b0);
  endtask

  logic [15:0] last_mask;
  logic [15:0] m;

  initial begin
    reset = 1'b0;
    kif.SEL = 2'd0;
    kif.ROW = 4'hF;

    do_reset();
    chk("reset_key", int'(kif.KEY), 0);
    chk("reset_down", int'(kif.KEY_DOWN), 0);

    // single press of 5, then release with a re-touch
    run_scans(16'h0020, 4);
    chk("press5_key", int'(kif.KEY), 5);
    chk("press5_down", int'(kif.KEY_DOWN), 1);
    run_scans(16'h0000, 3);
    run_scans(16'h0020, 1);
    chk("retouch_down", int'(kif.KEY_DOWN), 1);
    run_scans(16'h0000, 4);
    chk("release_down", int'(kif.KEY_DOWN), 0);
    chk("release_key", int'(kif.KEY), 5);

    // bounce on 9
    run_scans(16'h0200, 2);
    run_scans(16'h0000, 1);
    run_scans(16'h0200, 4);
    chk("bounce_key", int'(kif.KEY), 9);
    run_scans(16'h0000, 4);

    // multi-key after reset
    do_reset();
    run_scans(16'h0012, 10);
    chk("multi_key", int'(kif.KEY), 0);
    chk("multi_down", int'(kif.KEY_DOWN), 0);
    run_scans(16'h0000, 1);

    // reset during the third debounce scan of 7
    run_scans(16'h0080, 2);
    drive_sample(0, 16'h0080, 1'b1);
    drive_sample(1, 16'h0080, 1'b0);
    drive_sample(2, 16'h0080, 1'b1);
    drive_sample(3, 16'h0080, 1'b1);
    run_scans(16'h0080, 3);
    chk("rst_mid_down", int'(kif.KEY_DOWN), 0);
    run_scans(16'h0080, 1);
    chk("rst_mid_key", int'(kif.KEY), 7);
    run_scans(16'h0000, 4);

    // SEL glitch 0,1,3 discards the scan
    run_scans(16'h0004, 3);
    drive_sample(0, 16'h0004, 1'b1);
    drive_sample(1, 16'h0004, 1'b1);
    drive_sample(3, 16'h0004, 1'b1);
    chk("glitch_down", int'(kif.KEY_DOWN), 0);
    run_scans(16'h0004, 1);
    chk("glitch_key", int'(kif.KEY), 2);
    run_scans(16'h0000, 4);

    // long hold of # exercises auto-repeat when enabled
    run_scans(16'h8000, 22);
    chk("hold_key", int'(kif.KEY), 15);
    run_scans(16'h0000, 4);

    last_mask = 16'h0;
    for (int seg = 0; seg < 150; seg++) begin
      case ($urandom_range(0, 9))
        0: begin
          last_mask = 16'h1 << $urandom_range(0, 15);
          run_scans(last_mask, $urandom_range(10, 20));
        end
        1, 2, 3, 4: begin
          last_mask = 16'h1 << $urandom_range(0, 15);
          run_scans(last_mask, $urandom_range(1, 6));
        end
        5: run_scans(16'h0, $urandom_range(1, 4));
        6: begin
          m = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
          run_scans(m, $urandom_range(1, 3));
        end
        7: run_scans(last_mask | (16'h1 << $urandom_range(0, 15)), $urandom_range(1, 3));
        8: begin
          drive_sample(0, last_mask, 1'b1);
          drive_sample($urandom_range(0, 1) ? 1 : 2, last_mask, 1'b1);
          drive_sample(3, last_mask, 1'b1);
        end
        default: begin
          drive_sample(0, last_mask, 1'b1);
          drive_sample(1, last_mask, 1'b1);
          drive_sample(2, last_mask, 1'b0);
          drive_sample(3, last_mask, 1'b1);
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
